dpram_t_row_streamer: RTL and testbench

//  Read-side controller for the 64 x 512-bit transposed-matrix dual-port RAM (port A, read only).
//  - On start, issues num_rows consecutive row reads from base_addr (wrapping mod 64).
//  - Absorbs the RAM's 1-cycle registered read latency.
//  - Streams rows downstream on a valid/ready interface with full backpressure.
//  - Feeds the attention score/softmax datapath.

---
 rtl/dpram_t_row_streamer_pkg.sv | 17 +
 rtl/dpram_t_row_streamer_row_skid_fifo.sv | 65 ++++++
 rtl/dpram_t_row_streamer.sv | 155 +++++++++++++++
 tb/tb_dpram_t_row_streamer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_t_row_streamer_pkg.sv
// Shared constants and FSM encoding for the transposed-matrix RAM row streamer.
package dpram_t_row_streamer_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int NUM_WORDS    = 32;
    localparam int VECTOR_DEPTH = 64;
    localparam int ROW_W        = NUM_WORDS * DATA_WIDTH;
    localparam int ADDR_W       = $clog2(VECTOR_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dpram_t_row_streamer_row_skid_fifo.sv
// Small shift-register FIFO; entry 0 is the registered head presented downstream.
module row_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          valid,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [CW-1:0] count_r;
    logic          valid_r;
    logic          pop_ok_s;
    logic          push_ok_s;
    logic [CW-1:0] wr_idx_s;
    logic [CW-1:0] cnt_next_s;

    // Push/pop qualification and next occupancy.
    always_comb begin
        pop_ok_s  = pop && valid_r;
        push_ok_s = push && ((count_r < CW'(DEPTH)) || pop_ok_s);
        if (pop_ok_s) begin
            wr_idx_s = count_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            wr_idx_s = count_r;
        end
        cnt_next_s = wr_idx_s + {{(CW-1){1'b0}}, push_ok_s};
    end

    // Storage: shift toward the head on pop, then land the push at the first free slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            count_r <= {CW{1'b0}};
            valid_r <= 1'b0;
        end else begin
            if (pop_ok_s) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_r[i] <= mem_r[i+1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok_s && (wr_idx_s == CW'(i))) begin
                    mem_r[i] <= push_data;
                end
            end
            count_r <= cnt_next_s;
            valid_r <= (cnt_next_s != {CW{1'b0}});
        end
    end

    assign head  = mem_r[0];
    assign valid = valid_r;
    assign count = count_r;

endmodule

// File: rtl/dpram_t_row_streamer.sv
// Read-side controller: streams num_rows consecutive RAM rows from base_addr with
// credit-limited issue so the output FIFO never overflows under backpressure.
module dpram_t_row_streamer
    import dpram_t_row_streamer_pkg::*;
#(
    parameter int ADDR_W_P   = ADDR_W,
    parameter int DEPTH      = VECTOR_DEPTH,
    parameter int ROW_W_P    = ROW_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_W_P-1:0]           base_addr,
    input  logic [$clog2(DEPTH+1)-1:0]    num_rows,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_W_P-1:0]           ram_addr,
    output logic                          ram_wren,
    input  logic [ROW_W_P-1:0]            ram_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ROW_W_P-1:0]            out_data,
    output logic [ADDR_W_P-1:0]           out_idx,
    output logic                          out_last
);

    localparam int NW  = $clog2(DEPTH + 1);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = ROW_W_P + ADDR_W_P + 1;

    state_t              state_r, state_next_s;
    logic [ADDR_W_P-1:0] base_r, ram_addr_r, rd_idx_r, rd_idx_d_r;
    logic [NW-1:0]       num_r, issue_cnt_r;
    logic                rd_vld_r, rd_vld_d_r, rd_last_r, rd_last_d_r;
    logic                busy_r, done_r;
    logic                issue_s, pop_s, last_issue_s;
    logic [CW:0]         used_s;
    logic [CW-1:0]       fifo_cnt_s;
    logic [PW-1:0]       fifo_head_s;
    logic                fifo_valid_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = (num_rows == {NW{1'b0}}) ? DONE : ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (issue_s && last_issue_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            DRAIN: begin
                if (pop_s && out_last) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output/control decode: a read issues only while credit remains.
    always_comb begin
        used_s = {1'b0, fifo_cnt_s} + {{CW{1'b0}}, rd_vld_r} + {{CW{1'b0}}, rd_vld_d_r};
        last_issue_s = (issue_cnt_r == (num_r - {{(NW-1){1'b0}}, 1'b1}));
        pop_s = fifo_valid_s && out_ready;
        if (state_r == ISSUE) begin
            issue_s = (used_s < (CW+1)'(FIFO_DEPTH));
        end else begin
            issue_s = 1'b0;
        end
    end

    // Burst parameters, issue counter and the two-stage read-valid pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_r      <= {ADDR_W_P{1'b0}};
            num_r       <= {NW{1'b0}};
            issue_cnt_r <= {NW{1'b0}};
            ram_addr_r  <= {ADDR_W_P{1'b0}};
            rd_vld_r    <= 1'b0;
            rd_idx_r    <= {ADDR_W_P{1'b0}};
            rd_last_r   <= 1'b0;
            rd_vld_d_r  <= 1'b0;
            rd_idx_d_r  <= {ADDR_W_P{1'b0}};
            rd_last_d_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            if ((state_r == IDLE) && start) begin
                base_r      <= base_addr;
                num_r       <= num_rows;
                issue_cnt_r <= {NW{1'b0}};
            end else if (issue_s) begin
                issue_cnt_r <= issue_cnt_r + {{(NW-1){1'b0}}, 1'b1};
            end
            if (issue_s) begin
                ram_addr_r <= base_r + issue_cnt_r[ADDR_W_P-1:0];
                rd_idx_r   <= issue_cnt_r[ADDR_W_P-1:0];
                rd_last_r  <= last_issue_s;
            end
            rd_vld_r    <= issue_s;
            rd_vld_d_r  <= rd_vld_r;
            rd_idx_d_r  <= rd_idx_r;
            rd_last_d_r <= rd_last_r;
            busy_r      <= (state_next_s != IDLE);
            done_r      <= (state_next_s == DONE);
        end
    end

    row_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PW),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_vld_d_r),
        .push_data ({rd_last_d_r, rd_idx_d_r, ram_rdata}),
        .pop       (out_ready),
        .head      (fifo_head_s),
        .valid     (fifo_valid_s),
        .count     (fifo_cnt_s)
    );

    assign busy      = busy_r;
    assign done      = done_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wren  = 1'b0;
    assign out_valid = fifo_valid_s;
    assign out_data  = fifo_head_s[ROW_W_P-1:0];
    assign out_idx   = fifo_head_s[ROW_W_P+ADDR_W_P-1:ROW_W_P];
    assign out_last  = fifo_head_s[PW-1];

endmodule

// File: tb/tb_dpram_t_row_streamer.sv
// Scoreboard bench: a registered-read RAM model feeds the streamer; expected rows are
// queued when a burst is requested and a negedge monitor checks every handshake.
module tb_dpram_t_row_streamer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   base_addr;
    logic [6:0]   num_rows;
    logic         busy, done, ram_wren, out_valid, out_ready, out_last;
    logic [5:0]   ram_addr, out_idx;
    logic [511:0] ram_rdata, out_data;

    always #5 clk = ~clk;

    dpram_t_row_streamer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_wren  (ram_wren),
        .ram_rdata (ram_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [511:0] data;
        logic [5:0]   idx;
        logic         last;
    } exp_t;

    logic [511:0] mem [64];
    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    bit           rand_ready = 1'b0;
    bit           stalled = 1'b0;
    logic [518:0] held;

    // Port-A RAM: registered read, one cycle latency.
    always @(posedge clk) ram_rdata <= mem[ram_addr];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a burst; the model expects rows only when the block is known idle.
    task automatic start_burst(input logic [5:0] b, input logic [6:0] n, input bit expect_accept);
        base_addr = b;
        num_rows  = n;
        start     = 1'b1;
        if (expect_accept) begin
            for (int i = 0; i < n; i++) begin
                q.push_back('{data: mem[(b + i) % 64], idx: 6'(i), last: (i == n - 1)});
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || q.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) chk("wait_idle_timeout", 512'd0, 512'd1);
        repeat (3) tick();
    endtask

    task automatic end_of_burst(input string name, input int done_before);
        chk({name, "_done_pulses"}, 512'(done_cnt - done_before), 512'd1);
        chk({name, "_busy_low"}, 512'(busy), 512'd0);
        chk({name, "_rows_left"}, 512'(q.size()), 512'd0);
    endtask

    // Randomised backpressure, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 99) < 30);
        end
    end

    // Monitor: compare each accepted row and hold-stability during stalls.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (stalled && !out_valid) chk("valid_dropped", 512'd0, 512'd1);
            if (out_valid) begin
                if (stalled) chk("stall_stable", 512'({out_last, out_idx, out_data}), 512'(held));
                if (out_ready) begin
                    stalled = 1'b0;
                    if (q.size() == 0) begin
                        chk("unexpected_row", 512'(out_idx), 512'hDEAD);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_idx", 512'(out_idx), 512'(e.idx));
                        chk("out_last", 512'(out_last), 512'(e.last));
                    end
                end else begin
                    stalled = 1'b1;
                    held    = {out_last, out_idx, out_data};
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        int d0;
        int lat;
        logic [5:0] addr_before;
        for (int r = 0; r < 64; r++) begin
            for (int w = 0; w < 16; w++) mem[r][w*32 +: 32] = $urandom;
        end
        reset = 1'b1; start = 1'b0; base_addr = 6'd0; num_rows = 7'd0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 512'(busy), 512'd0);
        chk("rst_done", 512'(done), 512'd0);
        chk("rst_ram_addr", 512'(ram_addr), 512'd0);
        chk("rst_ram_wren", 512'(ram_wren), 512'd0);
        chk("rst_out_valid", 512'(out_valid), 512'd0);
        chk("rst_out_data", out_data, 512'd0);
        chk("rst_out_idx", 512'(out_idx), 512'd0);
        chk("rst_out_last", 512'(out_last), 512'd0);
        reset = 1'b0;
        tick();

        // 1: base 0, four rows, no backpressure; first row appears 4 cycles after start.
        d0 = done_cnt;
        start_burst(6'd0, 7'd4, 1'b1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("first_valid_latency", 512'(lat), 512'd4);
        wait_idle(200);
        end_of_burst("t1", d0);

        // 2: wrap-around 62,63,0,1.
        d0 = done_cnt;
        start_burst(6'd62, 7'd4, 1'b1);
        wait_idle(200);
        end_of_burst("t2", d0);

        // 3: full 64-row burst under random 30% ready.
        rand_ready = 1'b1;
        d0 = done_cnt;
        start_burst(6'($urandom_range(0, 63)), 7'd64, 1'b1);
        wait_idle(3000);
        end_of_burst("t3", d0);
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        // 4: empty burst: done only, no reads.
        d0 = done_cnt;
        addr_before = ram_addr;
        start_burst(6'd17, 7'd0, 1'b1);
        wait_idle(20);
        end_of_burst("t4", d0);
        chk("t4_ram_addr_untouched", 512'(ram_addr), 512'(addr_before));

        // 5: re-pulsed start during a burst is ignored.
        rand_ready = 1'b1;
        d0 = done_cnt;
        start_burst(6'd20, 7'd16, 1'b1);
        repeat (8) tick();
        start_burst(6'd3, 7'd3, 1'b0);
        wait_idle(1000);
        end_of_burst("t5", d0);
        rand_ready = 1'b0;

        // 6: reset while the FIFO is full and stalled, then a one-row burst.
        out_ready = 1'b0;
        start_burst(6'd10, 7'd8, 1'b1);
        repeat (12) tick();
        reset = 1'b1;
        tick();
        q.delete();
        chk("t6_rst_busy", 512'(busy), 512'd0);
        chk("t6_rst_done", 512'(done), 512'd0);
        chk("t6_rst_ram_addr", 512'(ram_addr), 512'd0);
        chk("t6_rst_out_valid", 512'(out_valid), 512'd0);
        chk("t6_rst_out_data", out_data, 512'd0);
        chk("t6_rst_out_idx", 512'(out_idx), 512'd0);
        chk("t6_rst_out_last", 512'(out_last), 512'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        d0 = done_cnt;
        start_burst(6'd5, 7'd1, 1'b1);
        wait_idle(200);
        end_of_burst("t6", d0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
